uart_rx: RTL and testbench
==========================

# uart_rx

8x-oversampling UART receiver. It consumes the 8x rx_clk from the baud-rate clock generator and deserialises the rxd line into parallel words. All logic runs on the system clock clk. rx_clk is used only as a data signal: its rising edges form the sample tick. The output is a one-cycle valid strobe with error flags, for a downstream FIFO or register file.

## Interface
- DATA_BITS, 8: data bits per frame, LSB first (legal 5..9).
- PARITY_EN, 0: 1 = one parity bit follows the data bits.
- PARITY_ODD, 0: parity sense when PARITY_EN=1 (0 = even, 1 = odd).

- clk  input  1  system clock; same clock that drives the baud generator.
- rst  input  1  reset; asynchronous, active-high.
- rx_clk  input  1  8x baud clock from the baud generator, synchronous to clk.
- rxd  input  1  serial line, asynchronous, idle high.
- rx_data  output  DATA_BITS  last received word; held until the next frame completes.
- rx_valid  output  1  one-clk pulse when a word with a good stop bit is delivered.
- parity_err  output  1  one-clk pulse, coincident with rx_valid, when parity mismatches.
- frame_err  output  1  one-clk pulse when the stop bit samples 0.
- rx_busy  output  1  high whenever the state is not IDLE.

## Operation
- Input conditioning:
  - rxd passes through a 2-flop synchroniser, reset to 1; rxd_s is the synchronised value.
  - rx_clk is registered once, reset to 0, giving rx_clk_d.
  - tick = rx_clk & ~rx_clk_d, a single-clk pulse.
  - The FSM, os_cnt (3 bits) and bit_cnt advance only on tick.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on a tick with rxd_s=0, go to START with os_cnt<=0.
- START: on each tick, if os_cnt==3 sample mid-bit, else increment os_cnt.
  - Sample 0: go to DATA with os_cnt<=0 and bit_cnt<=0.
  - Sample 1: false start; return to IDLE with no output.
- DATA: on each tick, if os_cnt==7, shift rxd_s into the MSB of the shift register (LSB-first), set os_cnt<=0 and bit_cnt++. Otherwise increment os_cnt.
  - After bit DATA_BITS-1 is sampled, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample at os_cnt==7 and store pbit, then go to STOP.
  - Check value is expected = ^shift ^ PARITY_ODD.
- STOP: sample at os_cnt==7.
  - Sample 1: rx_data<=shift; rx_valid=1; parity_err=(PARITY_EN && pbit!=expected). Go to IDLE immediately at mid-stop, so back-to-back frames are accepted.
  - Sample 0: rx_data is not updated; frame_err=1; rx_valid=0; go to WAIT_HIGH.
- WAIT_HIGH: stay until a tick sees rxd_s=1, then go to IDLE. A held-low line (break) therefore produces exactly one frame_err.
- rxd is not re-checked between mid-bit samples; no majority vote.
- Widths:
  - os_cnt wraps naturally at 7→0 but is always cleared explicitly.
  - bit_cnt is $clog2(DATA_BITS+1) bits.

## Timing
- Reset values:
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0.
  - State IDLE, os_cnt=0, bit_cnt=0, synchroniser=1, rx_clk_d=0.
- Reset mid-frame aborts the frame immediately. No strobe is emitted, and no strobe is emitted later for the aborted frame.
- Start-edge detection latency: 2 clk (synchroniser) plus up to one tick period.
- Sample points, counted in ticks after the detection tick:
  - start mid-bit at +4;
  - data bit k at +4+8(k+1);
  - parity at +4+8(DATA_BITS+1);
  - stop at +4+8(DATA_BITS+PARITY_EN+1). For 8N1 this is +76.
- Strobes: rx_valid, parity_err and frame_err are registered. They are high for exactly the one clk after the stop-sampling tick.
- rx_data changes in the same clk that rx_valid rises and is stable until the next rx_valid.
- rx_busy: rises the clk after the detection tick and falls the clk after the stop-sampling tick (for WAIT_HIGH, after the tick that exits it).
- Tick rate: with FREQUENCY=100 MHz and BAUD=115200, rx_clk period is 108 clk, so one bit time is 864 clk. Tolerance is ±3/8 bit accumulated over the frame.

## Test plan
All tests use 100 MHz / 115200 with rxd driven at 864 clk per bit.

1. 8N1 frame 0x55, idle line high before and after → rx_data=0x55; exactly one rx_valid pulse of 1 clk; frame_err=0; rx_busy low afterwards.
2. Back-to-back 0xA5 then 0x3C, stop bit followed directly by the next start → two rx_valid pulses 80 ticks apart; data 0xA5 then 0x3C.
3. rxd low for 2 ticks, then high → START rejects it; no strobes; rx_busy pulses and returns low; next 0x0F is received correctly.
4. Frame 0xFF with stop=0, then line held low for 20 bit times, then high, then frame 0x12:
   - exactly one frame_err pulse and no rx_valid for 0xFF; rx_data not updated by the 0xFF frame;
   - 0x12 received with rx_valid.
5. PARITY_EN=1, PARITY_ODD=0:
   - 0x07 with parity bit 0 → rx_valid with rx_data=0x07 and parity_err=1 in the same cycle;
   - 0x07 with parity bit 1 → parity_err=0.
6. rst pulsed during data bit 3 of 0xC3 → all outputs 0 during and after reset; no strobe for the aborted frame; after release, 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8x-oversampling UART receiver.
// rxd is synchronised into the clk domain. rising edges of rx_clk form a
// one-clk sample tick. A six-state FSM samples each bit in the middle and
// delivers the received word with one-clk valid/error strobes.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_clk,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam int BC_W = $clog2(DATA_BITS + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_t;

   // Expected parity bit for the received data word.
   function automatic logic parity_expected(input logic [DATA_BITS-1:0] d);
      return (^d) ^ (PARITY_ODD != 0);
   endfunction

   // Input conditioning
   logic rxd_p0;
   logic rxd_s;
   logic rx_clk_d;
   logic tick;

   // FSM and counters
   state_t          state;
   state_t          state_nxt;
   logic [2:0]      os_cnt;
   logic [BC_W-1:0] bit_cnt;

   // Datapath
   logic [DATA_BITS-1:0] shift;
   logic                 pbit;

   // Strobe decode
   logic mid_bit;
   logic stop_samp;
   logic valid_nxt;
   logic ferr_nxt;
   logic perr_nxt;

   // Two-flop synchroniser for the asynchronous serial line (idles high).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_p0 <= 1'b1;
         rxd_s  <= 1'b1;
      end else begin
         rxd_p0 <= rxd;
         rxd_s  <= rxd_p0;
      end
   end

   // Delay rx_clk by one clk so its rising edge can be detected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_clk_d <= 1'b0;
      end else begin
         rx_clk_d <= rx_clk;
      end
   end

   assign tick    = rx_clk & ~rx_clk_d;
   assign mid_bit = (os_cnt == 3'd7);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; the FSM only moves on a sample tick.
   always_comb begin
      state_nxt = state;
      if (tick) begin
         case (state)
            IDLE: begin
               if (!rxd_s) state_nxt = START;
            end
            START: begin
               if (os_cnt == 3'd3) state_nxt = rxd_s ? IDLE : DATA;
            end
            DATA: begin
               if (mid_bit && (bit_cnt == LAST_BIT))
                  state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
               if (mid_bit) state_nxt = STOP;
            end
            STOP: begin
               // Leave at mid-stop so a following start bit is not missed.
               if (mid_bit) state_nxt = rxd_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
               if (rxd_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Output decode: busy flag and next values of the registered strobes.
   always_comb begin
      rx_busy   = (state != IDLE);
      stop_samp = tick && (state == STOP) && mid_bit;
      valid_nxt = stop_samp && rxd_s;
      ferr_nxt  = stop_samp && !rxd_s;
      perr_nxt  = valid_nxt && (PARITY_EN != 0) && (pbit != parity_expected(shift));
   end

   // Oversample and bit counters; cleared explicitly at every bit boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         os_cnt  <= 3'd0;
         bit_cnt <= '0;
      end else if (tick) begin
         case (state)
            IDLE: begin
               os_cnt  <= 3'd0;
               bit_cnt <= '0;
            end
            START: begin
               if (os_cnt == 3'd3) begin
                  os_cnt  <= 3'd0;
                  bit_cnt <= '0;
               end else begin
                  os_cnt <= os_cnt + 3'd1;
               end
            end
            DATA: begin
               if (mid_bit) begin
                  os_cnt  <= 3'd0;
                  bit_cnt <= bit_cnt + BC_W'(1);
               end else begin
                  os_cnt <= os_cnt + 3'd1;
               end
            end
            PARITY, STOP: begin
               if (mid_bit) begin
                  os_cnt <= 3'd0;
               end else begin
                  os_cnt <= os_cnt + 3'd1;
               end
            end
            default: begin
               os_cnt <= 3'd0;
            end
         endcase
      end
   end

   // Shift register (LSB first into the MSB end) and captured parity bit.
   always_ff @(posedge clk) begin
      if (tick && (state == DATA) && mid_bit) begin
         shift <= {rxd_s, shift[DATA_BITS-1:1]};
      end
      if (tick && (state == PARITY) && mid_bit) begin
         pbit <= rxd_s;
      end
   end

   // Registered output word and one-clk strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid   <= valid_nxt;
         parity_err <= perr_nxt;
         frame_err  <= ferr_nxt;
         if (valid_nxt) begin
            rx_data <= shift;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: three receivers (two 8N1, one 8E1) driven by
// independent serial lines, with per-receiver expected-strobe queues.
module tb_uart_rx;

   localparam int BIT = 864;

   typedef struct packed {
      logic       frm;
      logic       perr;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rx_clk = 1'b0;
   logic rst_a = 1'b1, rst_b = 1'b1, rst_p = 1'b1;
   logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_p = 1'b1;

   logic [7:0] rx_data_a, rx_data_b, rx_data_p;
   logic rx_valid_a, rx_valid_b, rx_valid_p;
   logic parity_err_a, parity_err_b, parity_err_p;
   logic frame_err_a, frame_err_b, frame_err_p;
   logic rx_busy_a, rx_busy_b, rx_busy_p;

   int n_total = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_valid_a = 0, n_valid_b = 0, n_valid_p = 0;
   int n_ferr_a = 0, n_ferr_b = 0, n_ferr_p = 0;
   int last_t_a = 0, prev_t_a = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_p[$];

   uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
      .clk(clk), .rst(rst_a), .rx_clk(rx_clk), .rxd(rxd_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .parity_err(parity_err_a),
      .frame_err(frame_err_a), .rx_busy(rx_busy_a));

   uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_b (
      .clk(clk), .rst(rst_b), .rx_clk(rx_clk), .rxd(rxd_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .parity_err(parity_err_b),
      .frame_err(frame_err_b), .rx_busy(rx_busy_b));

   uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
      .clk(clk), .rst(rst_p), .rx_clk(rx_clk), .rxd(rxd_p),
      .rx_data(rx_data_p), .rx_valid(rx_valid_p), .parity_err(parity_err_p),
      .frame_err(frame_err_p), .rx_busy(rx_busy_p));

   // 100 MHz system clock
   always #5 clk = ~clk;

   // 8x baud tick source: 108 clk period
   initial begin
      forever begin
         repeat (54) @(negedge clk);
         rx_clk = ~rx_clk;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input int line, input logic val, input int nclk);
      case (line)
         0: rxd_a = val;
         1: rxd_b = val;
         default: rxd_p = val;
      endcase
      repeat (nclk) @(negedge clk);
   endtask

   task automatic send_frame(input int line, input logic [7:0] d, input logic stop,
                             input logic use_par, input logic pb);
      drive(line, 1'b0, BIT);
      for (int i = 0; i < 8; i++) drive(line, d[i], BIT);
      if (use_par) drive(line, pb, BIT);
      drive(line, stop, BIT);
   endtask

   // Scoreboard monitors: each strobe pops one expected entry
   always @(negedge clk) begin
      if (rx_valid_a || frame_err_a || parity_err_a) begin
         exp_t e;
         if (rx_valid_a) begin
            n_valid_a++;
            prev_t_a = last_t_a;
            last_t_a = cyc;
         end
         if (frame_err_a) n_ferr_a++;
         n_total++;
         if (q_a.size() == 0) begin
            n_fail++;
            $display("FAIL A_unexpected_strobe: got valid=%0b ferr=%0b perr=%0b data=0x%0h, expected no strobe",
                     rx_valid_a, frame_err_a, parity_err_a, rx_data_a);
         end else begin
            e = q_a.pop_front();
            check("A_valid", 32'(rx_valid_a), 32'(!e.frm));
            check("A_frame_err", 32'(frame_err_a), 32'(e.frm));
            check("A_parity_err", 32'(parity_err_a), 32'(e.perr));
            check("A_data", 32'(rx_data_a), 32'(e.data));
         end
      end
   end

   always @(negedge clk) begin
      if (rx_valid_b || frame_err_b || parity_err_b) begin
         exp_t e;
         if (rx_valid_b) n_valid_b++;
         if (frame_err_b) n_ferr_b++;
         n_total++;
         if (q_b.size() == 0) begin
            n_fail++;
            $display("FAIL B_unexpected_strobe: got valid=%0b ferr=%0b perr=%0b data=0x%0h, expected no strobe",
                     rx_valid_b, frame_err_b, parity_err_b, rx_data_b);
         end else begin
            e = q_b.pop_front();
            check("B_valid", 32'(rx_valid_b), 32'(!e.frm));
            check("B_frame_err", 32'(frame_err_b), 32'(e.frm));
            check("B_parity_err", 32'(parity_err_b), 32'(e.perr));
            check("B_data", 32'(rx_data_b), 32'(e.data));
         end
      end
   end

   always @(negedge clk) begin
      if (rx_valid_p || frame_err_p || parity_err_p) begin
         exp_t e;
         if (rx_valid_p) n_valid_p++;
         if (frame_err_p) n_ferr_p++;
         n_total++;
         if (q_p.size() == 0) begin
            n_fail++;
            $display("FAIL P_unexpected_strobe: got valid=%0b ferr=%0b perr=%0b data=0x%0h, expected no strobe",
                     rx_valid_p, frame_err_p, parity_err_p, rx_data_p);
         end else begin
            e = q_p.pop_front();
            check("P_valid", 32'(rx_valid_p), 32'(!e.frm));
            check("P_frame_err", 32'(frame_err_p), 32'(e.frm));
            check("P_parity_err", 32'(parity_err_p), 32'(e.perr));
            check("P_data", 32'(rx_data_p), 32'(e.data));
         end
      end
   end

   // Watchdog
   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got cycle budget exhausted, expected bench completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(negedge clk);
      check("A_reset_out", 32'({rx_data_a, rx_valid_a, parity_err_a, frame_err_a, rx_busy_a}), 32'd0);
      check("B_reset_out", 32'({rx_data_b, rx_valid_b, parity_err_b, frame_err_b, rx_busy_b}), 32'd0);
      check("P_reset_out", 32'({rx_data_p, rx_valid_p, parity_err_p, frame_err_p, rx_busy_p}), 32'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_p = 1'b0;
      repeat (5) @(negedge clk);

      fork
         // Receiver A: single frame, back-to-back, false start, reset abort
         begin
            bit saw_busy;
            drive(0, 1'b1, BIT);
            q_a.push_back('{frm: 1'b0, perr: 1'b0, data: 8'h55});
            send_frame(0, 8'h55, 1'b1, 1'b0, 1'b0);
            drive(0, 1'b1, BIT);
            check("T1_valid_count", 32'(n_valid_a), 32'd1);
            check("T1_data_held", 32'(rx_data_a), 32'h55);
            check("T1_busy_idle", 32'(rx_busy_a), 32'd0);
            check("T1_ferr_count", 32'(n_ferr_a), 32'd0);

            q_a.push_back('{frm: 1'b0, perr: 1'b0, data: 8'hA5});
            q_a.push_back('{frm: 1'b0, perr: 1'b0, data: 8'h3C});
            send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0);
            send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0);
            drive(0, 1'b1, BIT);
            check("T2_valid_count", 32'(n_valid_a), 32'd3);
            check("T2_spacing_clk", 32'(last_t_a - prev_t_a), 32'd8640);
            check("T2_data", 32'(rx_data_a), 32'h3C);

            saw_busy = 1'b0;
            rxd_a = 1'b0;
            for (int i = 0; i < 216; i++) begin
               @(negedge clk);
               if (rx_busy_a) saw_busy = 1'b1;
            end
            rxd_a = 1'b1;
            for (int i = 0; i < BIT; i++) begin
               @(negedge clk);
               if (rx_busy_a) saw_busy = 1'b1;
            end
            check("T3_busy_pulsed", 32'(saw_busy), 32'd1);
            check("T3_busy_back_low", 32'(rx_busy_a), 32'd0);
            check("T3_no_strobe", 32'(n_valid_a + n_ferr_a), 32'd3);
            q_a.push_back('{frm: 1'b0, perr: 1'b0, data: 8'h0F});
            send_frame(0, 8'h0F, 1'b1, 1'b0, 1'b0);
            drive(0, 1'b1, BIT);
            check("T3_valid_count", 32'(n_valid_a), 32'd4);
            check("T3_data", 32'(rx_data_a), 32'h0F);

            // 0xC3: start, bits 0..2 = 1,1,0, then half of bit 3 (0)
            drive(0, 1'b0, BIT);
            drive(0, 1'b1, BIT);
            drive(0, 1'b1, BIT);
            drive(0, 1'b0, BIT);
            drive(0, 1'b0, BIT / 2);
            check("T6_busy_mid_frame", 32'(rx_busy_a), 32'd1);
            rst_a = 1'b1;
            rxd_a = 1'b1;
            repeat (3) @(negedge clk);
            check("T6_out_in_reset",
                  32'({rx_data_a, rx_valid_a, parity_err_a, frame_err_a, rx_busy_a}), 32'd0);
            rst_a = 1'b0;
            drive(0, 1'b1, 6 * BIT);
            check("T6_out_after_reset",
                  32'({rx_data_a, rx_valid_a, parity_err_a, frame_err_a, rx_busy_a}), 32'd0);
            check("T6_no_strobe", 32'(n_valid_a + n_ferr_a), 32'd4);
            q_a.push_back('{frm: 1'b0, perr: 1'b0, data: 8'h81});
            send_frame(0, 8'h81, 1'b1, 1'b0, 1'b0);
            drive(0, 1'b1, BIT);
            check("T6_valid_count", 32'(n_valid_a), 32'd5);
            check("T6_data", 32'(rx_data_a), 32'h81);
         end

         // Receiver B: framing error followed by a break
         begin
            drive(1, 1'b1, BIT);
            q_b.push_back('{frm: 1'b1, perr: 1'b0, data: 8'h00});
            send_frame(1, 8'hFF, 1'b0, 1'b0, 1'b0);
            drive(1, 1'b0, 20 * BIT);
            check("T4_ferr_count", 32'(n_ferr_b), 32'd1);
            check("T4_busy_in_break", 32'(rx_busy_b), 32'd1);
            drive(1, 1'b1, BIT);
            check("T4_busy_after_break", 32'(rx_busy_b), 32'd0);
            check("T4_no_valid", 32'(n_valid_b), 32'd0);
            check("T4_data_untouched", 32'(rx_data_b), 32'h00);
            q_b.push_back('{frm: 1'b0, perr: 1'b0, data: 8'h12});
            send_frame(1, 8'h12, 1'b1, 1'b0, 1'b0);
            drive(1, 1'b1, BIT);
            check("T4_valid_count", 32'(n_valid_b), 32'd1);
            check("T4_ferr_final", 32'(n_ferr_b), 32'd1);
            check("T4_data", 32'(rx_data_b), 32'h12);
         end

         // Receiver P: even parity, 0x07 has odd weight so the good parity bit is 1
         begin
            drive(2, 1'b1, BIT);
            q_p.push_back('{frm: 1'b0, perr: 1'b1, data: 8'h07});
            send_frame(2, 8'h07, 1'b1, 1'b1, 1'b0);
            q_p.push_back('{frm: 1'b0, perr: 1'b0, data: 8'h07});
            send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1);
            drive(2, 1'b1, BIT);
            check("T5_valid_count", 32'(n_valid_p), 32'd2);
            check("T5_ferr_count", 32'(n_ferr_p), 32'd0);
            check("T5_busy_idle", 32'(rx_busy_p), 32'd0);
         end
      join

      check("A_pending", 32'(q_a.size()), 32'd0);
      check("B_pending", 32'(q_b.size()), 32'd0);
      check("P_pending", 32'(q_p.size()), 32'd0);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
